// File: rtl/ccff_pkg.sv
// ccff_pkg: shared state type and default sizes for the configuration-chain loader
package ccff_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
  localparam int NUM_CHAINS_DEF = 10;
  localparam int CHAIN_LEN_DEF = 1024;
  localparam int MISMATCH_CNT_W = 16;
endpackage

// File: rtl/ccff_tail_checker.sv
// ccff_tail_checker: readback compare of chain tails against the beat being shifted in
//   clr            clears all error fields (new load launched)
//   en             a verify-pass beat is being shifted this cycle
//   head/tail      chain input bits driven this cycle / chain output bits from fabric
//   beat           index of the beat currently on head
//   mismatch, mismatch_cnt (saturating), first_err_beat  error summary
module ccff_tail_checker
  import ccff_pkg::*;
#(
  parameter int NUM_CHAINS = NUM_CHAINS_DEF,
  parameter int CNT_W = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      en,
  input  logic [NUM_CHAINS-1:0]     head,
  input  logic [NUM_CHAINS-1:0]     tail,
  input  logic [CNT_W-1:0]          beat,
  output logic                      mismatch,
  output logic [MISMATCH_CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0]          first_err_beat
);
  logic err;
  assign err = en && (head != tail);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch       <= 1'b0;
      mismatch_cnt   <= '0;
      first_err_beat <= '0;
    end else if (clr) begin
      mismatch       <= 1'b0;
      mismatch_cnt   <= '0;
      first_err_beat <= '0;
    end else if (err) begin
      mismatch       <= 1'b1;
      mismatch_cnt   <= &mismatch_cnt ? mismatch_cnt : mismatch_cnt + MISMATCH_CNT_W'(1);
      first_err_beat <= mismatch ? first_err_beat : beat;
    end
  end
endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: shifts a beat-per-cycle bitstream into parallel config chains, with optional readback verify
//   start/verify        launch a load (verify=1 adds a second, compared pass)
//   s_data/s_valid/s_ready  one bit per chain per accepted beat
//   ccff_head/prog_clk_en   registered chain inputs and shift enable to the fabric
//   ccff_tail               chain outputs from the fabric
//   config_enable/cfg_done/busy  configuration status
//   mismatch/mismatch_cnt/first_err_beat  verify-pass error summary
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int NUM_CHAINS = NUM_CHAINS_DEF,
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      verify,
  input  logic [NUM_CHAINS-1:0]     s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [NUM_CHAINS-1:0]     ccff_head,
  input  logic [NUM_CHAINS-1:0]     ccff_tail,
  output logic                      prog_clk_en,
  output logic                      config_enable,
  output logic                      cfg_done,
  output logic                      busy,
  output logic                      mismatch,
  output logic [MISMATCH_CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0]          first_err_beat
);
  state_t state, state_nx;
  logic [CNT_W-1:0] beat_cnt, head_beat;
  logic verify_q, chk_q, launch, accept, last;
  assign launch = start && (state == IDLE || state == DONE);
  assign accept = s_valid && s_ready;
  assign last = accept && beat_cnt == CNT_W'(CHAIN_LEN - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = launch ? LOAD
             : (state == LOAD && last) ? (verify_q ? VERIFY : DONE)
             : (state == VERIFY && last) ? DONE
             : state;
  end
  // The last beat's shift pulse lands in the first cycle after LOAD/VERIFY, so
  // config_enable is stretched over it and cfg_done waits until it has passed.
  always_comb begin
    s_ready = state == LOAD || state == VERIFY;
    busy = s_ready;
    config_enable = s_ready || prog_clk_en;
    cfg_done = state == DONE && !prog_clk_en;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccff_head   <= '0;
      prog_clk_en <= 1'b0;
      chk_q       <= 1'b0;
      head_beat   <= '0;
      beat_cnt    <= '0;
      verify_q    <= 1'b0;
    end else begin
      prog_clk_en <= accept;
      chk_q       <= accept && state == VERIFY;
      ccff_head   <= accept ? s_data : ccff_head;
      head_beat   <= accept ? beat_cnt : head_beat;
      verify_q    <= launch ? verify : verify_q;
      beat_cnt    <= (launch || last) ? '0 : accept ? beat_cnt + CNT_W'(1) : beat_cnt;
    end
  end
  ccff_tail_checker #(.NUM_CHAINS(NUM_CHAINS), .CNT_W(CNT_W)) u_chk (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (launch),
    .en             (chk_q),
    .head           (ccff_head),
    .tail           (ccff_tail),
    .beat           (head_beat),
    .mismatch       (mismatch),
    .mismatch_cnt   (mismatch_cnt),
    .first_err_beat (first_err_beat)
  );
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: randomized scenario bench with a fabric shift-chain model and stream-level reference
module tb_ccff_bitstream_loader;
  localparam int NC = 10;
  localparam int CL = 16;
  localparam int CW = $clog2(CL + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic verify = 1'b0;
  logic s_valid = 1'b0;
  logic [NC-1:0] s_data = '0;
  logic [NC-1:0] ccff_head, ccff_tail;
  logic s_ready, prog_clk_en, config_enable, cfg_done, busy, mismatch;
  logic [15:0] mismatch_cnt;
  logic [CW-1:0] first_err_beat;
  logic [CL-1:0] fab [NC];
  logic [NC-1:0] p1 [CL];
  logic [NC-1:0] p2 [CL];
  int pulses = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ccff_bitstream_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .verify(verify),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_clk_en(prog_clk_en),
    .config_enable(config_enable), .cfg_done(cfg_done), .busy(busy),
    .mismatch(mismatch), .mismatch_cnt(mismatch_cnt), .first_err_beat(first_err_beat)
  );

  always @(posedge clk) if (prog_clk_en) for (int i = 0; i < NC; i++) fab[i] <= {fab[i][CL-2:0], ccff_head[i]};
  always @(posedge clk) if (prog_clk_en) pulses <= pulses + 1;
  always_comb for (int i = 0; i < NC; i++) ccff_tail[i] = fab[i][CL-1];

  // Beat k of a complete load must sit k places from the chain output.
  function automatic int chain_errs();
    int e = 0;
    for (int k = 0; k < CL; k++)
      for (int i = 0; i < NC; i++)
        if (fab[i][CL-1-k] !== p1[k][i]) e++;
    return e;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < CL; k++) begin
      p1[k] = NC'($urandom);
      p2[k] = p1[k];
    end
  endtask

  task automatic start_load(input logic v);
    start = 1'b1;
    verify = v;
    @(negedge clk);
    start = 1'b0;
    verify = 1'b0;
  endtask

  task automatic send(input logic [NC-1:0] d);
    s_valid = 1'b1;
    s_data = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic finish_pass(output logic pen0, output logic ce0, output logic cd0, output int cyc);
    pen0 = prog_clk_en;
    ce0 = config_enable;
    cd0 = cfg_done;
    cyc = 0;
    while (!cfg_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ccff_head !== '0) begin n_bad++; $display("FAIL reset_head: got %h want 0", ccff_head); end
    n_cmp++; if ({prog_clk_en, config_enable, cfg_done, busy, s_ready} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {prog_clk_en, config_enable, cfg_done, busy, s_ready}); end
    n_cmp++; if ({mismatch, mismatch_cnt, first_err_beat} !== '0) begin n_bad++; $display("FAIL reset_err: got %b/%0d/%0d want 0", mismatch, mismatch_cnt, first_err_beat); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plain_load();
    logic pen0, ce0, cd0;
    int cyc, base;
    for (int k = 0; k < CL; k++) p1[k] = k[0] ? 10'h2AA : 10'h155;
    base = pulses;
    start_load(1'b0);
    for (int k = 0; k < CL; k++) send(p1[k]);
    finish_pass(pen0, ce0, cd0, cyc);
    n_cmp++; if (pulses - base !== CL) begin n_bad++; $display("FAIL plain_pulses: got %0d want %0d", pulses - base, CL); end
    n_cmp++; if (chain_errs() !== 0) begin n_bad++; $display("FAIL plain_chain: got %0d bad bits want 0", chain_errs()); end
    n_cmp++; if ({pen0, ce0, cd0} !== 3'b110) begin n_bad++; $display("FAIL plain_tail_cycle: got pen/ce/done %b want 110", {pen0, ce0, cd0}); end
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL plain_done_latency: got %0d want 1", cyc); end
    n_cmp++; if ({cfg_done, busy, s_ready, config_enable, mismatch} !== 5'b10000) begin n_bad++; $display("FAIL plain_final: got %b want 10000", {cfg_done, busy, s_ready, config_enable, mismatch}); end
  endtask

  task automatic test_verify_clean();
    logic pen0, ce0, cd0;
    int cyc, base;
    fill_random();
    base = pulses;
    start_load(1'b1);
    for (int k = 0; k < CL; k++) send(p1[k]);
    n_cmp++; if ({busy, cfg_done} !== 2'b10) begin n_bad++; $display("FAIL clean_between: got busy/done %b want 10", {busy, cfg_done}); end
    for (int k = 0; k < CL; k++) send(p2[k]);
    finish_pass(pen0, ce0, cd0, cyc);
    n_cmp++; if (pulses - base !== 2 * CL) begin n_bad++; $display("FAIL clean_pulses: got %0d want %0d", pulses - base, 2 * CL); end
    n_cmp++; if (chain_errs() !== 0) begin n_bad++; $display("FAIL clean_chain: got %0d bad bits want 0", chain_errs()); end
    n_cmp++; if ({cfg_done, mismatch, mismatch_cnt} !== {2'b10, 16'd0}) begin n_bad++; $display("FAIL clean_result: got done=%b mm=%b cnt=%0d want 1/0/0", cfg_done, mismatch, mismatch_cnt); end
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL clean_done_latency: got %0d want 1", cyc); end
  endtask

  task automatic run_verify(output int cyc, output int ec, output int ef);
    logic pen0, ce0, cd0;
    ec = 0;
    ef = 0;
    for (int k = 0; k < CL; k++) if (p2[k] != p1[k]) begin if (ec == 0) ef = k; ec++; end
    start_load(1'b1);
    for (int k = 0; k < CL; k++) send(p1[k]);
    for (int k = 0; k < CL; k++) send(p2[k]);
    finish_pass(pen0, ce0, cd0, cyc);
  endtask

  task automatic test_verify_errors();
    int cyc, ec, ef;
    fill_random();
    p2[5][3] = ~p2[5][3];
    p2[9][3] = ~p2[9][3];
    run_verify(cyc, ec, ef);
    n_cmp++; if (mismatch !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", mismatch); end
    n_cmp++; if (mismatch_cnt !== 16'd2) begin n_bad++; $display("FAIL err_count: got %0d want 2", mismatch_cnt); end
    n_cmp++; if (first_err_beat !== CW'(5)) begin n_bad++; $display("FAIL err_first: got %0d want 5", first_err_beat); end
    n_cmp++; if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL err_done: got %b want 1", cfg_done); end
  endtask

  task automatic test_verify_random();
    int cyc, ec, ef;
    for (int r = 0; r < 4; r++) begin
      fill_random();
      for (int k = 0; k < CL; k++) if ($urandom_range(3) == 0) p2[k] ^= NC'($urandom_range(1, 1023));
      run_verify(cyc, ec, ef);
      n_cmp++; if ({mismatch, mismatch_cnt, first_err_beat} !== {ec != 0, 16'(ec), CW'(ef)}) begin n_bad++; $display("FAIL rand_verify[%0d]: got mm=%b cnt=%0d first=%0d want %b/%0d/%0d", r, mismatch, mismatch_cnt, first_err_beat, ec != 0, ec, ef); end
      n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL rand_done_latency[%0d]: got %0d want 1", r, cyc); end
    end
  endtask

  task automatic test_gap();
    logic pen0, ce0, cd0;
    int cyc, base;
    fill_random();
    base = pulses;
    start_load(1'b0);
    for (int k = 0; k < CL; k++) begin
      send(p1[k]);
      if (k == 7)
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          n_cmp++; if ({prog_clk_en, ccff_head} !== {1'b0, p1[7]}) begin n_bad++; $display("FAIL gap_hold[%0d]: got pen=%b head=%h want 0/%h", g, prog_clk_en, ccff_head, p1[7]); end
        end
    end
    finish_pass(pen0, ce0, cd0, cyc);
    n_cmp++; if (pulses - base !== CL) begin n_bad++; $display("FAIL gap_pulses: got %0d want %0d", pulses - base, CL); end
    n_cmp++; if (chain_errs() !== 0) begin n_bad++; $display("FAIL gap_chain: got %0d bad bits want 0", chain_errs()); end
    n_cmp++; if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL gap_done: got %b want 1", cfg_done); end
  endtask

  task automatic test_start_ignored();
    logic pen0, ce0, cd0;
    int cyc, base;
    fill_random();
    base = pulses;
    start_load(1'b0);
    n_cmp++; if ({mismatch, mismatch_cnt, first_err_beat} !== '0) begin n_bad++; $display("FAIL ign_cleared: got %b/%0d/%0d want 0", mismatch, mismatch_cnt, first_err_beat); end
    for (int k = 0; k < CL; k++) begin
      if (k == 4) begin start = 1'b1; verify = 1'b1; end
      send(p1[k]);
      start = 1'b0;
      verify = 1'b0;
    end
    finish_pass(pen0, ce0, cd0, cyc);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL ign_done_latency: got %0d want 1", cyc); end
    n_cmp++; if (pulses - base !== CL) begin n_bad++; $display("FAIL ign_pulses: got %0d want %0d", pulses - base, CL); end
    n_cmp++; if ({cfg_done, busy, mismatch} !== 3'b100) begin n_bad++; $display("FAIL ign_final: got done/busy/mm %b want 100", {cfg_done, busy, mismatch}); end
    n_cmp++; if (chain_errs() !== 0) begin n_bad++; $display("FAIL ign_chain: got %0d bad bits want 0", chain_errs()); end
  endtask

  task automatic test_reset_mid_load();
    logic pen0, ce0, cd0;
    int cyc, base;
    fill_random();
    start_load(1'b0);
    for (int k = 0; k < 10; k++) send(p1[k]);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({ccff_head, prog_clk_en, config_enable, cfg_done, busy, s_ready, mismatch, mismatch_cnt, first_err_beat} !== '0) begin n_bad++; $display("FAIL midrst_outputs: got head=%h pen=%b ce=%b done=%b busy=%b rdy=%b want all 0", ccff_head, prog_clk_en, config_enable, cfg_done, busy, s_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, cfg_done, prog_clk_en} !== 3'b000) begin n_bad++; $display("FAIL midrst_idle: got %b want 000", {busy, cfg_done, prog_clk_en}); end
    fill_random();
    base = pulses;
    start_load(1'b0);
    for (int k = 0; k < CL; k++) send(p1[k]);
    finish_pass(pen0, ce0, cd0, cyc);
    n_cmp++; if (pulses - base !== CL) begin n_bad++; $display("FAIL midrst_pulses: got %0d want %0d", pulses - base, CL); end
    n_cmp++; if (chain_errs() !== 0) begin n_bad++; $display("FAIL midrst_chain: got %0d bad bits want 0", chain_errs()); end
    n_cmp++; if ({cfg_done, cyc} !== {1'b1, 32'd1}) begin n_bad++; $display("FAIL midrst_done: got done=%b lat=%0d want 1/1", cfg_done, cyc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_plain_load();
    test_verify_clean();
    test_verify_errors();
    test_start_ignored();
    test_verify_random();
    test_gap();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
